// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch resolution unit: comparator modes,
// instruction-kind encodings, FSM states and the registered result record.
package branch_unit_pkg;

    localparam logic [2:0] CMP_LT  = 3'b000;
    localparam logic [2:0] CMP_LTU = 3'b001;
    localparam logic [2:0] CMP_GE  = 3'b010;
    localparam logic [2:0] CMP_GEU = 3'b011;
    localparam logic [2:0] CMP_EQ  = 3'b100;
    localparam logic [2:0] CMP_NEQ = 3'b101;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SQUASH = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] link;
        logic        taken;
        logic        illegal;
        logic        misalign;
    } result_t;

endpackage

// File: rtl/branch_unit_cmp.sv
// Operand comparator: evaluates one signed/unsigned relation selected by mode_i.
module branch_unit_cmp
    import branch_unit_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  mode_i,
    output logic        result_o
);

    always_comb begin
        result_o = 1'b0;
        case (mode_i)
            CMP_LT:  result_o = $signed(a_i) <  $signed(b_i);
            CMP_LTU: result_o = a_i <  b_i;
            CMP_GE:  result_o = $signed(a_i) >= $signed(b_i);
            CMP_GEU: result_o = a_i >= b_i;
            CMP_EQ:  result_o = a_i == b_i;
            CMP_NEQ: result_o = a_i != b_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution: registers the resolved result, raises a one-cycle
// redirect/flush on mispredict and keeps a saturating mispredict count.
//   state  | meaning
//   RUN    | accepting beats, presenting the last result
//   SQUASH | one-cycle redirect/flush; beats taken here are wrong-path and dropped
//   HOLD   | downstream stalled, result held, no new beats
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_kind,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_link,
    output logic             out_taken,
    output logic             out_illegal,
    output logic             out_misalign,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    function automatic logic [2:0] f3_to_mode(input logic [2:0] f3);
        case (f3)
            F3_BEQ:  return CMP_EQ;
            F3_BNE:  return CMP_NEQ;
            F3_BLT:  return CMP_LT;
            F3_BGE:  return CMP_GE;
            F3_BLTU: return CMP_LTU;
            F3_BGEU: return CMP_GEU;
            default: return CMP_EQ;
        endcase
    endfunction

    state_e           state_q, state_d;
    result_t          res_q, res_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        cmp_res;
    logic        is_jump, is_jalr, illegal, taken, misalign, mispredict;
    logic [31:0] pc_sum, rs_sum, target, link;
    logic        load;

    branch_unit_cmp u_cmp (
        .a_i      (in_rs1),
        .b_i      (in_rs2),
        .mode_i   (f3_to_mode(in_funct3)),
        .result_o (cmp_res)
    );

    // Reserved kind decodes as a conditional branch.
    always_comb begin
        is_jalr  = (in_kind == KIND_JALR);
        is_jump  = (in_kind == KIND_JAL) || is_jalr;
        illegal  = !is_jump && ((in_funct3 == 3'b010) || (in_funct3 == 3'b011));
        taken    = illegal ? 1'b0 : (is_jump ? 1'b1 : cmp_res);
        pc_sum   = in_pc + in_imm;
        rs_sum   = in_rs1 + in_imm;
        target   = is_jalr ? (rs_sum & 32'hFFFF_FFFE) : pc_sum;
        link     = in_pc + 32'd4;
        misalign = taken && target[1];
        mispredict = !misalign && !illegal &&
                     ((taken != in_pred_taken) || (taken && (target != in_pred_target)));
    end

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        in_ready      = 1'b1;
        load          = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (in_valid) begin
                    load        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = mispredict ? ST_SQUASH : ST_RUN;
                end else if (out_valid_q && !out_ready) begin
                    state_d = ST_HOLD;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SQUASH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                in_ready = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        res_d         = res_q;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        if (load) begin
            res_d.link     = link;
            res_d.taken    = taken;
            res_d.illegal  = illegal;
            res_d.misalign = misalign;
            redirect_pc_d  = taken ? target : link;
            if (mispredict && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            res_q         <= '0;
            redirect_pc_q <= '0;
            out_valid_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            res_q         <= res_d;
            redirect_pc_q <= redirect_pc_d;
            out_valid_q   <= out_valid_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_link       = res_q.link;
    assign out_taken      = res_q.taken;
    assign out_illegal    = res_q.illegal;
    assign out_misalign   = res_q.misalign;
    assign redirect_valid = (state_q == ST_SQUASH);
    assign flush          = redirect_valid;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule
